// File: rtl/pipe_mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: data RAM, memory-mapped I/O ports,
// switch-input synchronisers and the registered write-back bundle.
module pipe_mem_wb_stage #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        MEM_wreg,
  input  logic        MEM_m2reg,
  input  logic        MEM_wmem,
  input  logic [31:0] MEM_alu,
  input  logic [31:0] MEM_datain,
  input  logic [4:0]  MEM_write_reg_number,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic        WB_wreg,
  output logic        WB_m2reg,
  output logic [31:0] WB_alu,
  output logic [31:0] WB_mo,
  output logic [4:0]  WB_write_reg_number,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  logic [31:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_idx;
  logic        io_space;
  logic [1:0]  io_sel;
  logic        ram_we;
  logic        io_we;
  logic [31:0] ram_rd;
  logic [31:0] io_rd;
  logic [31:0] mo;

  logic        wb_wreg_q, wb_wreg_d;
  logic        wb_m2reg_q, wb_m2reg_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_mo_q, wb_mo_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic [31:0] out2_q, out2_d;
  logic [31:0] in0_s1_q, in0_s1_d;
  logic [31:0] in0_sync_q, in0_sync_d;
  logic [31:0] in1_s1_q, in1_s1_d;
  logic [31:0] in1_sync_q, in1_sync_d;

  // Only the decoded address bits are used; the rest alias by design.
  logic unused_alu;
  assign unused_alu = ^MEM_alu;

  // Address decode, load-data mux and next-state for every register.
  always_comb begin
    io_space = MEM_alu[7];
    io_sel   = MEM_alu[3:2];
    ram_idx  = MEM_alu[AW+1:2];
    ram_we   = MEM_wmem & ~io_space;
    io_we    = MEM_wmem & io_space;
    ram_rd   = ram_mem[ram_idx];

    case (io_sel)
      2'b00:   io_rd = in0_sync_q;
      2'b01:   io_rd = in1_sync_q;
      2'b10:   io_rd = out0_q;
      default: io_rd = out2_q;
    endcase
    mo = io_space ? io_rd : ram_rd;

    out0_d = out0_q;
    out1_d = out1_q;
    out2_d = out2_q;
    if (io_we) begin
      case (io_sel)
        2'b00:   out0_d = MEM_datain;
        2'b01:   out1_d = MEM_datain;
        2'b10:   out2_d = MEM_datain;
        default: ;
      endcase
    end

    wb_wreg_d  = MEM_wreg;
    wb_m2reg_d = MEM_m2reg;
    wb_alu_d   = MEM_alu;
    wb_mo_d    = mo;
    wb_rd_d    = MEM_write_reg_number;

    in0_s1_d   = in_port0;
    in0_sync_d = in0_s1_q;
    in1_s1_d   = in_port1;
    in1_sync_d = in1_s1_q;
  end

  // Data RAM is not reset; a store caught by reset is dropped.
  always_ff @(posedge clock) begin
    if (ram_we && resetn) ram_mem[ram_idx] <= MEM_datain;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_wreg_q  <= 1'b0;
      wb_m2reg_q <= 1'b0;
      wb_alu_q   <= 32'd0;
      wb_mo_q    <= 32'd0;
      wb_rd_q    <= 5'd0;
      out0_q     <= 32'd0;
      out1_q     <= 32'd0;
      out2_q     <= 32'd0;
      in0_s1_q   <= 32'd0;
      in0_sync_q <= 32'd0;
      in1_s1_q   <= 32'd0;
      in1_sync_q <= 32'd0;
    end else begin
      wb_wreg_q  <= wb_wreg_d;
      wb_m2reg_q <= wb_m2reg_d;
      wb_alu_q   <= wb_alu_d;
      wb_mo_q    <= wb_mo_d;
      wb_rd_q    <= wb_rd_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      in0_s1_q   <= in0_s1_d;
      in0_sync_q <= in0_sync_d;
      in1_s1_q   <= in1_s1_d;
      in1_sync_q <= in1_sync_d;
    end
  end

  assign WB_wreg             = wb_wreg_q;
  assign WB_m2reg            = wb_m2reg_q;
  assign WB_alu              = wb_alu_q;
  assign WB_mo               = wb_mo_q;
  assign WB_write_reg_number = wb_rd_q;
  assign out_port0           = out0_q;
  assign out_port1           = out1_q;
  assign out_port2           = out2_q;

endmodule

// File: doc/pipe_mem_wb_stage.md
# pipe_mem_wb_stage

Memory stage plus MEM/WB pipeline register of the five-stage pipelined CPU. It consumes the EXE/MEM register outputs (MEM_* control, ALU result, store data, destination register). It performs the data-memory or memory-mapped I/O access and registers the write-back bundle for the WB stage. It also owns the board I/O: it synchronises the switch inputs and holds the output-port registers driving the LEDs and 7-segment displays.

## Interface
- DEPTH_LOG2, 5: log2 of data-RAM depth in 32-bit words; legal range 1..5.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- MEM_wreg  in  1  instruction writes the register file.
- MEM_m2reg  in  1  write-back value comes from memory (load).
- MEM_wmem  in  1  store instruction.
- MEM_alu  in  32  effective address, or the ALU result for non-memory ops.
- MEM_datain  in  32  store data.
- MEM_write_reg_number  in  5  destination register.
- in_port0  in  32  asynchronous switch input 0.
- in_port1  in  32  asynchronous switch input 1.
- WB_wreg  out  1  registered MEM_wreg.
- WB_m2reg  out  1  registered MEM_m2reg.
- WB_alu  out  32  registered MEM_alu.
- WB_mo  out  32  registered load data.
- WB_write_reg_number  out  5  registered destination register.
- out_port0  out  32  I/O output register 0.
- out_port1  out  32  I/O output register 1.
- out_port2  out  32  I/O output register 2.

## Operation
- Address decode uses MEM_alu[7].
  - 0: RAM space. Word index is MEM_alu[DEPTH_LOG2+1:2]. Bits [1:0] and all bits above the index are ignored, so the RAM aliases.
  - 1: I/O space. Port select is MEM_alu[3:2]. All other bits are ignored.
- RAM: 2^DEPTH_LOG2 x 32.
  - Read is combinational.
  - Write is synchronous and happens when MEM_wmem=1 and MEM_alu[7]=0.
  - RAM contents are not affected by reset.
- I/O reads, selected by MEM_alu[3:2]:
  - 00: in0_sync
  - 01: in1_sync
  - 10: out_port0
  - 11: out_port2
- I/O writes, when MEM_wmem=1 and MEM_alu[7]=1, selected by MEM_alu[3:2]:
  - 00: out_port0
  - 01: out_port1
  - 10: out_port2
  - 11: write is ignored; nothing changes.
- Input synchroniser: each in_port passes through two flops (in_portN -> s1 -> in_N_sync). Software reads the value that was present two edges earlier.
- Load data mo is the RAM read or the I/O read mux, selected by MEM_alu[7]. mo is computed every cycle regardless of MEM_m2reg.
- MEM/WB register: on each edge, capture MEM_wreg, MEM_m2reg, MEM_alu, mo and MEM_write_reg_number into the WB_* outputs. There is no stall or flush input.
- Store with MEM_wreg=1 is a decoder error. The block still performs both actions independently.

## Timing
- Reset (resetn=0, asynchronous) clears the following to 0 immediately, without waiting for a clock edge:
  - all WB_* outputs
  - out_port0, out_port1, out_port2
  - both synchroniser stages
- RAM is untouched by reset. The bench must write a word before reading it.
- Latency:
  - MEM_* inputs appear on WB_* one edge later.
  - A store is visible to a load in the next cycle: store at edge k, load in cycle k+1 reads the new data.
  - An output-port write appears on out_portN one edge after the store is in the MEM stage.
- Same-cycle read/write: only one instruction is in MEM, so a store's own mo reflects the pre-write contents. WB_mo for a store is don't-care to the pipeline, but it must equal the old contents.
- A reset asserted mid-cycle cancels any pending store. Out ports stay 0 after the release edge until a new store arrives.
- Reset release is synchronous to clock in the system. No recovery behaviour is required beyond that.

## Test plan
- Reset: drive resetn=0 mid-cycle with nonzero inputs. All WB_* and out_port* must read 0 at once, and stay 0 through two edges while reset is held.
- RAM round-trip: store 0xDEADBEEF to 0x0C, then load 0x0C next cycle. Expect WB_mo=0xDEADBEEF and WB_m2reg=1. Load 0x8C (DEPTH_LOG2=5) and expect 0xDEADBEEF via aliasing? No: 0x8C is I/O space. Load 0x10C instead and expect 0xDEADBEEF.
- I/O output: store 0x12345678 to 0x80. Expect out_port0=0x12345678 after one edge. Load 0x88 and expect WB_mo=0x12345678. Store to 0x8C and expect all out ports unchanged.
- Input synchroniser: set in_port1=0xA5A5A5A5 at cycle 0 and load 0x84 every cycle. WB_mo stays 0 through the edge-2 result and shows 0xA5A5A5A5 from the edge-3 result on.
- Pass-through: ALU op with MEM_alu=0x7FFFFFFF, wreg=1, rd=17, m2reg=0. Expect WB_alu=0x7FFFFFFF, WB_write_reg_number=17, WB_wreg=1 one edge later, and RAM unchanged.
- Back-to-back stores: store 1 to 0x00, 2 to 0x04, 3 to 0x00 on consecutive cycles, then load 0x00 and 0x04. Expect 3 then 2.
